// File: rtl/counter_pkg.sv
// Shared types and signed-limit helpers for the step counter family.
package counter_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   function automatic longint signed_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint signed_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/step_addsub.sv
// Combinational signed add/subtract of an unsigned step, one guard bit wide,
// with overflow/underflow detection against the WIDTH-bit signed range.
module step_addsub #(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] operand,
   input  logic        [WIDTH-1:0] step,
   input  logic                    up,
   output logic signed [WIDTH:0]   result,
   output logic                    ovf,
   output logic                    unf
);

   logic signed [WIDTH:0] op_ext;
   logic signed [WIDTH:0] step_ext;

   assign op_ext   = {operand[WIDTH-1], operand};
   assign step_ext = {1'b0, step};
   assign result   = up ? (op_ext + step_ext) : (op_ext - step_ext);

   // Top two bits disagreeing means the value left the WIDTH-bit signed range.
   assign ovf = (result[WIDTH:WIDTH-1] == 2'b01);
   assign unf = (result[WIDTH:WIDTH-1] == 2'b10);

endmodule

// File: rtl/updown_step_counter.sv
// Signed up/down counter with separate up/down steps, load and wrap/saturate.
// Saturation is built only when UPDOWN_STEP_COUNTER_SAT_EN is defined.
module updown_step_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int STEP_UP = 5,
   parameter int STEP_DN = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    up,
   input  logic                    ld,
   input  logic signed [WIDTH-1:0] ld_val,
   input  logic                    sat_mode,
   output logic signed [WIDTH-1:0] count,
   output logic                    ovf,
   output logic                    at_max,
   output logic                    at_min
);

   localparam logic signed [WIDTH-1:0] CNT_MAX   = WIDTH'(signed_max(WIDTH));
   localparam logic signed [WIDTH-1:0] CNT_MIN   = WIDTH'(signed_min(WIDTH));
   localparam logic        [WIDTH-1:0] STEP_UP_W = WIDTH'(STEP_UP);
   localparam logic        [WIDTH-1:0] STEP_DN_W = WIDTH'(STEP_DN);

   logic signed [WIDTH-1:0] count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    at_max_q, at_max_d;
   logic                    at_min_q, at_min_d;

   logic        [WIDTH-1:0] step_sel;
   logic signed [WIDTH:0]   sum_w;
   logic                    ovf_w;
   logic                    unf_w;
   logic                    unused_sum_msb;

   assign step_sel       = up ? STEP_UP_W : STEP_DN_W;
   assign unused_sum_msb = sum_w[WIDTH];

   step_addsub #(
      .WIDTH (WIDTH)
   ) u_step_addsub (
      .operand (count_q),
      .step    (step_sel),
      .up      (up),
      .result  (sum_w),
      .ovf     (ovf_w),
      .unf     (unf_w)
   );

`ifdef UPDOWN_STEP_COUNTER_SAT_EN
   cnt_mode_e mode;
   assign mode = sat_mode ? CNT_SAT : CNT_WRAP;
`else
   logic unused_sat_mode;
   assign unused_sat_mode = sat_mode;
`endif

   always_comb begin
      count_d = count_q;
      ovf_d   = 1'b0;
      if (ld) begin
         count_d = ld_val;
      end else if (en) begin
         count_d = sum_w[WIDTH-1:0];
         if (ovf_w || unf_w) begin
            ovf_d = 1'b1;
`ifdef UPDOWN_STEP_COUNTER_SAT_EN
            if (mode == CNT_SAT) begin
               count_d = ovf_w ? CNT_MAX : CNT_MIN;
            end
`endif
         end
      end
      // Flags follow the value being stored so they line up with count.
      at_max_d = (count_d == CNT_MAX);
      at_min_d = (count_d == CNT_MIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         ovf_q    <= 1'b0;
         at_max_q <= 1'b0;
         at_min_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
      end
   end

   assign count  = count_q;
   assign ovf    = ovf_q;
   assign at_max = at_max_q;
   assign at_min = at_min_q;

endmodule

// File: tb/tb_updown_step_counter.sv
// Self-checking bench for updown_step_counter (WIDTH=8, STEP_UP=5, STEP_DN=1):
// directed vector table, reset-mid-count sequence and randomized model compare.
module tb_updown_step_counter;

`ifdef UPDOWN_STEP_COUNTER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic              clk;
   logic              rst_n;
   logic              en;
   logic              up;
   logic              ld;
   logic signed [7:0] ld_val;
   logic              sat_mode;
   logic signed [7:0] count;
   logic              ovf;
   logic              at_max;
   logic              at_min;

   int checks   = 0;
   int failures = 0;

   updown_step_counter #(
      .WIDTH   (8),
      .STEP_UP (5),
      .STEP_DN (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .ld       (ld),
      .ld_val   (ld_val),
      .sat_mode (sat_mode),
      .count    (count),
      .ovf      (ovf),
      .at_max   (at_max),
      .at_min   (at_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit ld;
      int ld_val;
      bit en;
      bit up;
      bit sat;
      int exp_count;
      bit exp_ovf;
      bit exp_max;
      bit exp_min;
   } vec_t;

   // Behavioural reference state.
   int m_count;
   bit m_ovf;

   task automatic check(input string name, input int exp_c, input bit exp_o,
                        input bit exp_mx, input bit exp_mn);
      checks++;
      if (int'(count) != exp_c || ovf != exp_o || at_max != exp_mx || at_min != exp_mn) begin
         failures++;
         $display("FAIL %s: got count=%0d ovf=%0b at_max=%0b at_min=%0b, expected count=%0d ovf=%0b at_max=%0b at_min=%0b",
                  name, count, ovf, at_max, at_min, exp_c, exp_o, exp_mx, exp_mn);
      end else begin
         $display("ok   %s: count=%0d ovf=%0b at_max=%0b at_min=%0b", name, count, ovf, at_max, at_min);
      end
   endtask

   task automatic drive(input bit l, input int lv, input bit e, input bit u, input bit s);
      ld       = l;
      ld_val   = 8'(lv);
      en       = e;
      up       = u;
      sat_mode = s;
   endtask

   // Next state from the arithmetic rules: exact integer result, then clip or wrap.
   task automatic model_step(input bit l, input int lv, input bit e, input bit u, input bit s);
      int r;
      m_ovf = 1'b0;
      if (l) begin
         m_count = lv;
      end else if (e) begin
         r = u ? m_count + 5 : m_count - 1;
         if (r > 127) begin
            m_ovf   = 1'b1;
            m_count = (SAT_EN && s) ? 127 : r - 256;
         end else if (r < -128) begin
            m_ovf   = 1'b1;
            m_count = (SAT_EN && s) ? -128 : r + 256;
         end else begin
            m_count = r;
         end
      end
   endtask

   vec_t vecs[15];

   initial begin
      vecs[0]  = '{0,   0, 1, 1, 0,   5, 0, 0, 0};
      vecs[1]  = '{0,   0, 1, 1, 0,  10, 0, 0, 0};
      vecs[2]  = '{0,   0, 1, 1, 0,  15, 0, 0, 0};
      vecs[3]  = '{1, 125, 0, 0, 0, 125, 0, 0, 0};
      vecs[4]  = '{0,   0, 1, 1, 0,-126, 1, 0, 0};
      vecs[5]  = '{1, 125, 0, 0, 1, 125, 0, 0, 0};
      vecs[6]  = SAT_EN ? '{0, 0, 1, 1, 1, 127, 1, 1, 0} : '{0, 0, 1, 1, 1, -126, 1, 0, 0};
      vecs[7]  = SAT_EN ? '{0, 0, 1, 1, 1, 127, 1, 1, 0} : '{0, 0, 1, 1, 1, -121, 0, 0, 0};
      vecs[8]  = '{1,-128, 0, 0, 0,-128, 0, 0, 1};
      vecs[9]  = '{0,   0, 1, 0, 0, 127, 1, 1, 0};
      vecs[10] = '{1,-128, 0, 0, 1,-128, 0, 0, 1};
      vecs[11] = SAT_EN ? '{0, 0, 1, 0, 1, -128, 1, 0, 1} : '{0, 0, 1, 0, 1, 127, 1, 1, 0};
      vecs[12] = '{1,  42, 1, 1, 1,  42, 0, 0, 0};
      vecs[13] = '{0,   0, 0, 1, 0,  42, 0, 0, 0};
      vecs[14] = '{0,   0, 1, 0, 0,  41, 0, 0, 0};

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      #1;
      check("reset_async", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("reset_held", 0, 0, 0, 0);
      rst_n = 1'b1;

      // Directed table: inputs applied one cycle, outputs checked after the edge.
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].ld, vecs[i].ld_val, vecs[i].en, vecs[i].up, vecs[i].sat);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ovf,
               vecs[i].exp_max, vecs[i].exp_min);
      end

      // Reset between edges discards progress, then counting restarts from zero.
      drive(1, 20, 0, 0, 0);
      @(posedge clk);
      #1;
      check("load20", 20, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midcycle_reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("restart_1", 5, 0, 0, 0);
      @(posedge clk);
      #1;
      check("restart_2", 10, 0, 0, 0);

      // Randomized run against the integer model.
      m_count = 10;
      m_ovf   = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         bit l, e, u, s;
         int lv;
         l  = ($urandom_range(0, 15) == 0);
         lv = $urandom_range(0, 255) - 128;
         e  = ($urandom_range(0, 3) != 0);
         u  = ($urandom_range(0, 2) != 0) ^ (n[9]);
         s  = $urandom_range(0, 1);
         drive(l, lv, e, u, s);
         model_step(l, lv, e, u, s);
         @(posedge clk);
         #1;
         check($sformatf("rand%0d", n), m_count, m_ovf, m_count == 127, m_count == -128);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
